sm_minmax_frame: RTL and testbench

- Downstream consumer of the sign-magnitude comparator (o_out = 1 when a >= b).
- Accepts a stream of N-bit sign-magnitude samples in frames of FRAME_LEN samples.
- Tracks the running maximum and minimum of each frame, plus the index of each.
- Presents per-frame results through a valid/ready output handshake; it contains two comparator instances and the control around them.

---
 rtl/sm_minmax_frame.sv | 156 +++++++++++++++
 tb/tb_sm_minmax_frame.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sm_minmax_frame.sv
// Frame min/max tracker for N-bit sign-magnitude samples.
// Each frame of FRAME_LEN samples yields its maximum and minimum and the
// 0-based index of each. Ties keep the earliest index. Values are ordered by
// the sign-magnitude comparator below, so +0 ranks above -0.

// Sign-magnitude comparator: o_out = 1 when i_a >= i_b.
module sm_cmp #(
   parameter int N = 8
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   output logic         o_out
);

   logic         sign_a;
   logic         sign_b;
   logic [N-2:0] mag_a;
   logic [N-2:0] mag_b;

   assign sign_a = i_a[N-1];
   assign sign_b = i_b[N-1];
   assign mag_a  = i_a[N-2:0];
   assign mag_b  = i_b[N-2:0];

   // A plus value beats a minus value, including +0 against -0. When the
   // signs match, a larger magnitude wins for plus and a smaller one for minus.
   always_comb begin
      o_out = 1'b0;
      if (sign_a != sign_b) begin
         o_out = ~sign_a;
      end else if (!sign_a) begin
         o_out = (mag_a >= mag_b);
      end else begin
         o_out = (mag_a <= mag_b);
      end
   end

endmodule

module sm_minmax_frame #(
   parameter  int N         = 8,
   parameter  int FRAME_LEN = 16,
   localparam int IW        = $clog2(FRAME_LEN)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_clear,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic [N-1:0]  i_data,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [N-1:0]  o_max,
   output logic [IW-1:0] o_max_idx,
   output logic [N-1:0]  o_min,
   output logic [IW-1:0] o_min_idx
);

   // Handshake: a sample moves on a rising edge where i_valid && o_ready, and
   // a result moves on a rising edge where o_valid && i_ready. Once asserted,
   // o_valid stays high and the result stays stable until it is taken or
   // i_clear drops it. o_ready and o_valid come only from the registered
   // state, so there is no combinational path from i_valid or i_ready.

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_HOLD    = 1'b1
   } state_t;

   localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

   state_t        state_q;
   logic [IW-1:0] count_q;
   logic [N-1:0]  max_q;
   logic [IW-1:0] max_idx_q;
   logic [N-1:0]  min_q;
   logic [IW-1:0] min_idx_q;

   logic max_ge_data;   // current max >= incoming sample
   logic data_ge_min;   // incoming sample >= current min

   sm_cmp #(.N(N)) u_cmp_max (
      .i_a   (max_q),
      .i_b   (i_data),
      .o_out (max_ge_data)
   );

   sm_cmp #(.N(N)) u_cmp_min (
      .i_a   (i_data),
      .i_b   (min_q),
      .o_out (data_ge_min)
   );

   // Frame control and result tracking. i_clear outranks every other update.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_COLLECT;
         count_q   <= '0;
         max_q     <= '0;
         max_idx_q <= '0;
         min_q     <= '0;
         min_idx_q <= '0;
      end else if (i_clear) begin
         // The result registers keep their values; the next first sample
         // overwrites them.
         state_q <= ST_COLLECT;
         count_q <= '0;
      end else begin
         case (state_q)
            ST_COLLECT: begin
               if (i_valid) begin
                  if (count_q == '0) begin
                     max_q     <= i_data;
                     max_idx_q <= '0;
                     min_q     <= i_data;
                     min_idx_q <= '0;
                  end else begin
                     // Only a strict improvement moves a result, so a tie
                     // keeps the earliest index.
                     if (!max_ge_data) begin
                        max_q     <= i_data;
                        max_idx_q <= count_q;
                     end
                     if (!data_ge_min) begin
                        min_q     <= i_data;
                        min_idx_q <= count_q;
                     end
                  end
                  if (count_q == LAST_IDX) begin
                     count_q <= '0;
                     state_q <= ST_HOLD;
                  end else begin
                     count_q <= count_q + IW'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (i_ready) begin
                  state_q <= ST_COLLECT;
               end
            end
            default: begin
               state_q <= ST_COLLECT;
            end
         endcase
      end
   end

   assign o_ready   = (state_q == ST_COLLECT);
   assign o_valid   = (state_q == ST_HOLD);
   assign o_max     = max_q;
   assign o_max_idx = max_idx_q;
   assign o_min     = min_q;
   assign o_min_idx = min_idx_q;

endmodule

// File: tb/tb_sm_minmax_frame.sv
// Directed bench for sm_minmax_frame with N=8 and FRAME_LEN=4.
// Inputs change 1 ns after a rising edge, and outputs are sampled at the
// same point. Every expected value below is worked out by hand.
module tb_sm_minmax_frame;

   localparam int N         = 8;
   localparam int FRAME_LEN = 4;
   localparam int IW        = $clog2(FRAME_LEN);

   logic          i_clk;
   logic          i_rst_n;
   logic          i_clear;
   logic          i_valid;
   logic          o_ready;
   logic [N-1:0]  i_data;
   logic          o_valid;
   logic          i_ready;
   logic [N-1:0]  o_max;
   logic [IW-1:0] o_max_idx;
   logic [N-1:0]  o_min;
   logic [IW-1:0] o_min_idx;

   int vectors;
   int miscompares;

   sm_minmax_frame #(.N(N), .FRAME_LEN(FRAME_LEN)) dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_clear   (i_clear),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .i_data    (i_data),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_max     (o_max),
      .o_max_idx (o_max_idx),
      .o_min     (o_min),
      .o_min_idx (o_min_idx)
   );

   // Clock: 10 ns period.
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_hs(input string tag, input logic exp_valid, input logic exp_ready);
      chk({tag, "_valid"}, 32'(o_valid), 32'(exp_valid));
      chk({tag, "_ready"}, 32'(o_ready), 32'(exp_ready));
   endtask

   task automatic chk_res(input string tag, input logic [N-1:0] mx, input logic [IW-1:0] mx_i,
                          input logic [N-1:0] mn, input logic [IW-1:0] mn_i);
      chk({tag, "_max"},     32'(o_max),     32'(mx));
      chk({tag, "_max_idx"}, 32'(o_max_idx), 32'(mx_i));
      chk({tag, "_min"},     32'(o_min),     32'(mn));
      chk({tag, "_min_idx"}, 32'(o_min_idx), 32'(mn_i));
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Present one sample for one edge. While collecting, that edge accepts it.
   task automatic send(input logic [N-1:0] d);
      i_valid = 1'b1;
      i_data  = d;
      tick();
      i_valid = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      i_rst_n = 1'b1;
      i_clear = 1'b0;
      i_valid = 1'b0;
      i_data  = '0;
      i_ready = 1'b0;
      #2 i_rst_n = 1'b0;
      #1;
      chk_hs("reset", 1'b0, 1'b1);
      chk_res("reset", 8'h00, 2'd0, 8'h00, 2'd0);
      tick();
      tick();
      i_rst_n = 1'b1;
      tick();

      // 1: basic frame, downstream always ready.
      i_ready = 1'b1;
      send(8'h05);
      send(8'h83);
      send(8'h7F);
      chk_hs("t1_mid", 1'b0, 1'b1);
      send(8'hFF);
      chk_hs("t1_done", 1'b1, 1'b0);
      chk_res("t1", 8'h7F, 2'd2, 8'hFF, 2'd3);
      tick();
      chk_hs("t1_taken", 1'b0, 1'b1);
      chk_res("t1_keep", 8'h7F, 2'd2, 8'hFF, 2'd3);

      // 2: ties keep the earliest index.
      send(8'h03);
      send(8'h03);
      send(8'h83);
      send(8'h83);
      chk_hs("t2_done", 1'b1, 1'b0);
      chk_res("t2", 8'h03, 2'd0, 8'h83, 2'd2);
      tick();

      // 3: +0 ranks above -0.
      send(8'h80);
      send(8'h00);
      send(8'h80);
      send(8'h00);
      chk_hs("t3_done", 1'b1, 1'b0);
      chk_res("t3", 8'h00, 2'd1, 8'h80, 2'd0);
      tick();

      // 4: backpressure. Samples offered during the hold must not count.
      i_ready = 1'b0;
      send(8'h10);
      send(8'h20);
      send(8'h30);
      send(8'h40);
      i_valid = 1'b1;
      i_data  = 8'h11;
      for (int i = 0; i < 5; i++) begin
         chk_hs("t4_hold", 1'b1, 1'b0);
         chk_res("t4_hold", 8'h40, 2'd3, 8'h10, 2'd0);
         tick();
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      tick();
      chk_hs("t4_taken", 1'b0, 1'b1);
      send(8'h50);
      send(8'h01);
      send(8'h02);
      send(8'h81);
      chk_hs("t4_next", 1'b1, 1'b0);
      chk_res("t4_next", 8'h50, 2'd0, 8'h81, 2'd3);
      tick();

      // 5: abort mid-frame. The sample offered with i_clear is dropped.
      i_ready = 1'b0;
      send(8'h7F);
      send(8'hFF);
      i_clear = 1'b1;
      send(8'h20);
      i_clear = 1'b0;
      chk_hs("t5_clear", 1'b0, 1'b1);
      chk_res("t5_clear", 8'h7F, 2'd0, 8'hFF, 2'd1);
      send(8'h01);
      send(8'h02);
      send(8'h83);
      chk_hs("t5_mid", 1'b0, 1'b1);
      send(8'h04);
      chk_hs("t5_done", 1'b1, 1'b0);
      chk_res("t5", 8'h04, 2'd3, 8'h83, 2'd2);
      // A clear during the hold drops the pending result but keeps the values.
      i_clear = 1'b1;
      tick();
      i_clear = 1'b0;
      chk_hs("t5_hclr", 1'b0, 1'b1);
      chk_res("t5_hclr", 8'h04, 2'd3, 8'h83, 2'd2);

      // 6: asynchronous reset mid-frame, then again during a hold.
      send(8'h12);
      send(8'h34);
      #2 i_rst_n = 1'b0;
      #1;
      chk_hs("t6_rst1", 1'b0, 1'b1);
      chk_res("t6_rst1", 8'h00, 2'd0, 8'h00, 2'd0);
      #2 i_rst_n = 1'b1;
      tick();
      send(8'h22);
      send(8'hA2);
      send(8'h33);
      send(8'hB3);
      chk_hs("t6_frame", 1'b1, 1'b0);
      chk_res("t6_frame", 8'h33, 2'd2, 8'hB3, 2'd3);
      #2 i_rst_n = 1'b0;
      #1;
      chk_hs("t6_rst2", 1'b0, 1'b1);
      chk_res("t6_rst2", 8'h00, 2'd0, 8'h00, 2'd0);
      #2 i_rst_n = 1'b1;
      tick();
      send(8'h01);
      send(8'h02);
      send(8'h03);
      send(8'h04);
      chk_hs("t6_after", 1'b1, 1'b0);
      chk_res("t6_after", 8'h04, 2'd3, 8'h01, 2'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
